// File: rtl/spike_event_arbiter.sv
// Spike event arbiter: captures level events from N synchronizers, rearms them with a timed
// clear pulse, and serialises pending events round-robin onto a valid/ready address stream.
// Optional per-event timestamps are enabled by defining EVT_TIMESTAMP_EN.
module spike_event_arbiter #(
  parameter int N          = 8,
  parameter int AW         = 3,
  parameter int CLR_CYCLES = 2,
`ifdef EVT_TIMESTAMP_EN
  parameter int TS_W       = 16,
`endif
  parameter int DROP_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_clr_n,
  input  logic [N-1:0]      i_sync,
  output logic [N-1:0]      o_sync_clr,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [AW-1:0]     o_addr,
  output logic [N-1:0]      o_pending,
`ifdef EVT_TIMESTAMP_EN
  output logic [TS_W-1:0]   o_tstamp,
`endif
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam int CW = $clog2(CLR_CYCLES + 1);
  localparam int SW = DROP_W + $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_LOW
  } ch_state_t;

  ch_state_t      state_q [N];
  ch_state_t      state_d [N];
  logic [CW-1:0]  cnt_q   [N];
  logic [CW-1:0]  cnt_d   [N];

  logic [N-1:0]   capture;
  logic [N-1:0]   clr_d;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   pending_d;
  logic [N-1:0]   grant_oh;
  logic [N-1:0]   drop;
  logic [AW-1:0]  ptr_q;
  logic [AW-1:0]  ptr_next;
  logic [AW-1:0]  grant_idx;
  logic [AW-1:0]  idx;
  logic           grant_any;
  logic           load_en;
  logic [SW-1:0]  drop_sum;
  logic [DROP_W-1:0] drop_next;

  // Per-channel capture / clear / wait-for-low sequencing.
  // NOTE: every variable is given a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    capture = '0;
    clr_d   = '0;
    for (int k = 0; k < N; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        ST_IDLE: begin
          if (i_sync[k]) begin
            capture[k] = 1'b1;
            state_d[k] = ST_CLEAR;
            cnt_d[k]   = CW'(CLR_CYCLES);
          end
        end
        ST_CLEAR: begin
          if (cnt_q[k] <= CW'(1)) begin
            state_d[k] = ST_WAIT_LOW;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k] = cnt_q[k] - CW'(1);
          end
        end
        ST_WAIT_LOW: begin
          if (!i_sync[k]) state_d[k] = ST_IDLE;
        end
        default: state_d[k] = ST_IDLE;
      endcase
      clr_d[k] = (state_d[k] == ST_CLEAR);
    end
  end

  // Round-robin search: first pending bit at or above the pointer, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = AW'((int'(ptr_q) + i) % N);
      if (!grant_any && pending_q[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign ptr_next  = (grant_idx == AW'(N - 1)) ? '0 : grant_idx + AW'(1);
  assign load_en   = !o_valid || i_ready;
  assign grant_oh  = (load_en && grant_any) ? (N'(1) << grant_idx) : '0;
  // A capture landing on the edge that hands the old event to the output is queued, not dropped.
  assign pending_d = (pending_q & ~grant_oh) | capture;
  assign drop      = capture & pending_q & ~grant_oh;
  assign o_pending = pending_q;

  always_comb begin
    drop_sum  = SW'(o_drop_cnt) + SW'($countones(drop));
    drop_next = (drop_sum > SW'({DROP_W{1'b1}})) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they are reset too.
      for (int k = 0; k < N; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
      o_sync_clr <= '0;
      pending_q  <= '0;
      o_drop_cnt <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      o_sync_clr <= clr_d;
      pending_q  <= pending_d;
      o_drop_cnt <= drop_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      o_valid <= 1'b0;
      o_addr  <= '0;
      ptr_q   <= '0;
    end else if (load_en) begin
      o_valid <= grant_any;
      if (grant_any) begin
        o_addr <= grant_idx;
        ptr_q  <= ptr_next;
      end
    end
  end

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_mem [N];

  // Coalesced captures overwrite the stored time with the newer one.
  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      ts_cnt   <= '0;
      o_tstamp <= '0;
      for (int k = 0; k < N; k++) ts_mem[k] <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      for (int k = 0; k < N; k++) begin
        if (capture[k]) ts_mem[k] <= ts_cnt;
      end
      if (load_en && grant_any) o_tstamp <= ts_mem[grant_idx];
    end
  end
`endif

endmodule

// File: doc/spike_event_arbiter.md
Name: spike_event_arbiter

Overview:
- Collects level-type spike events from N per-neuron synchronizers and rearms each synchronizer by pulsing its clear.
- Queues one pending event per channel and serialises pending events round-robin into a single valid/ready address stream for the synapse processing unit.
- Sits between the synchronizer bank and the synapse/weight-update sequencer of the 8-neuron core.

Parameters:
N, 8, number of event channels (synchronizer instances)
AW, 3, address width; must satisfy 2^AW >= N
CLR_CYCLES, 2, clock cycles o_sync_clr is held high per capture (>=1)
DROP_W, 8, width of the saturating drop counter

Ports:
i_clk  in  1  system clock; all state on rising edge
i_clr_n  in  1  asynchronous active-low reset
i_sync  in  N  synchronizer outputs; bit k high = event pending at source k, held until cleared
o_sync_clr  out  N  per-channel clear to the synchronizers (active-high, registered)
o_valid  out  1  event address available
i_ready  in  1  consumer accepts o_addr when o_valid && i_ready
o_addr  out  AW  index of the granted channel
o_pending  out  N  current pending bitmap (debug)
o_drop_cnt  out  DROP_W  count of coalesced (lost) events, saturating

Behaviour:
- Reset (i_clr_n low, asynchronous): all channel FSMs go to IDLE. Outputs o_sync_clr=0, o_valid=0, o_addr=0, o_pending=0, o_drop_cnt=0. Round-robin pointer resets to 0 (channel 0 has highest priority first).
- Reset mid-operation: any in-flight clear pulse, pending bits and the held output are discarded. No event is reported after reset release until a fresh i_sync high is sampled.
- Per-channel FSM (k = 0..N-1):
  - IDLE: if i_sync[k]=1 at an edge -> CLEAR; in the same edge set pending[k] and load the clear counter with CLR_CYCLES.
  - CLEAR: o_sync_clr[k]=1; decrement the counter; at 0 -> WAIT_LOW.
  - WAIT_LOW: o_sync_clr[k]=0; stay until i_sync[k]=0, then -> IDLE. This covers the synchronizer output delay after clear.
  - A stuck-high i_sync therefore produces exactly one event per CLEAR/WAIT_LOW cycle, never a continuous stream.
- Capture while pending[k] is already 1: pending stays 1 (coalesced); o_drop_cnt += 1, saturating at 2^DROP_W-1. The clear sequence still runs.
- Output register:
  - Loads when o_valid=0, or when o_valid=1 && i_ready=1 (back-to-back throughput: 1 event/cycle).
  - Load selects the first set pending bit searching upward from the pointer, wrapping N-1 -> 0.
  - On load: o_addr=granted index, o_valid=1, pending[granted] cleared, pointer = granted+1 mod N.
  - If no bit is pending at a load opportunity, o_valid goes 0.
- Simultaneous load-clear and capture on the same channel in one cycle: pending ends at 1 and no drop is counted (the old event is in the output register, the new one is queued).
- Handshake: o_addr and o_valid stay stable while o_valid=1 && i_ready=0. i_ready while o_valid=0 has no effect.
- Latency: i_sync[k] first sampled high at edge t -> pending[k]=1 after t -> o_valid=1 with o_addr=k after edge t+1, provided the output register is free and k wins arbitration. o_sync_clr[k] is high for edges t+1..t+CLR_CYCLES.
- Fairness: with all N channels pending continuously, each channel is granted exactly once per N accepted events.

Optional Feature:
Macro EVT_TIMESTAMP_EN.
- Defined: adds parameter TS_W (default 16), a free-running TS_W-bit cycle counter (reset 0, wraps), and port o_tstamp (out, TS_W).
  - A per-channel timestamp is captured at the same edge pending[k] is set. Coalesced captures overwrite it with the newer time.
  - o_tstamp is loaded alongside o_addr and is stable under the same handshake rule.
  - o_tstamp resets to 0.
- Undefined: no counter, no per-channel timestamp storage, no o_tstamp port; the rest of the behaviour is identical.

Test Plan:
- Reset release, i_sync=8'h00, i_ready=1 for 20 cycles -> o_valid=0, o_sync_clr=0, o_drop_cnt=0 throughout.
- i_sync[5] high at edge t, i_ready=1 -> o_valid=1 with o_addr=5 after edge t+1 for one cycle. o_sync_clr[5] high for exactly 2 cycles. The model synchronizer drops i_sync[5]; the FSM returns to IDLE.
- i_sync=8'hFF in one cycle, i_ready=1 -> o_addr sequence 0,1,2,...,7 on consecutive cycles, then o_valid=0. All 8 clear pulses occur.
- i_ready=0 with pending channels 2 and 6 -> o_addr=2 held stable for 10 cycles. On i_ready=1: 2 then 6 accepted.
- i_ready=0 and channel 3 event captured twice (two rearm cycles) before grant -> exactly one o_addr=3 delivered; o_drop_cnt=1. After 300 further such drops, o_drop_cnt=255 (saturated).
- Assert i_clr_n=0 while o_valid=1 and a clear pulse is active -> o_valid, o_sync_clr, o_pending and o_drop_cnt go 0 immediately. After release, no stale event appears.
